// File: rtl/dco_trim_pkg.sv
// Shared types and helpers for the DCO trim calibrator.
package dco_trim_pkg;

    localparam int unsigned TRIM_MAX  = 26;
    localparam int unsigned TRIM_BITS = 26;
    localparam int unsigned LVL_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        VERIFY,
        MONITOR
    } state_t;

    // Thermometer code: the lowest 'level' bits are set.
    function automatic logic [TRIM_BITS-1:0] trim_therm(input logic [LVL_W-1:0] level);
        logic [TRIM_BITS-1:0] t;
        t = '0;
        for (int i = 0; i < int'(TRIM_BITS); i++) begin
            t[i] = (i < int'(level));
        end
        return t;
    endfunction

endpackage

// File: rtl/osc_period_meter.sv
// Synchronises the reference osc, flags its rising edges and counts DCO
// cycles between them with a saturating counter.
module osc_period_meter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             osc,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1;
    logic             sync2;
    logic             osc_prev;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser followed by a registered rising-edge flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            osc_prev   <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= osc;
            sync2      <= sync1;
            osc_prev   <= sync2;
            edge_pulse <= sync2 & ~osc_prev;
        end
    end

    // Period counter: a clear wins over an edge; otherwise restart at 1 on an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (edge_pulse) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign period = cnt;
    assign sat    = (cnt == CNT_MAX);

endmodule

// File: rtl/dco_trim_calibrator.sv
// Binary-search calibration of the DCO ring trim against the reference osc,
// followed by continuous lock monitoring.
module dco_trim_calibrator
    import dco_trim_pkg::*;
#(
    parameter int unsigned SETTLE_EDGES = 2,
    parameter int unsigned LOCK_TOL     = 1,
    parameter int unsigned FAIL_LIMIT   = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 osc,
    input  logic [LVL_W-1:0]     div,
    output logic                 dco,
    output logic [TRIM_BITS-1:0] ext_trim,
    output logic [LVL_W-1:0]     trim_level,
    output logic                 busy,
    output logic                 locked,
    output logic                 cal_fail,
    output logic                 no_osc
);

    localparam int unsigned SET_W  = $clog2(SETTLE_EDGES + 1);
    localparam int unsigned MISS_W = $clog2(FAIL_LIMIT + 1);
    localparam logic [LVL_W-1:0] TRIM_MID = LVL_W'(TRIM_MAX >> 1);

    state_t            state;
    logic [LVL_W-1:0]  div_q;
    logic [LVL_W-1:0]  lo;
    logic [LVL_W-1:0]  hi;
    logic              verifying;
    logic [SET_W-1:0]  settle_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [CNT_W-1:0]  count_q;

    logic              edge_pulse;
    logic [CNT_W-1:0]  period;
    logic              sat;
    logic              accept;

    logic [LVL_W:0]    sum;
    logic [LVL_W-1:0]  mid;
    logic [LVL_W-1:0]  new_lo;
    logic [LVL_W-1:0]  new_hi;
    logic [LVL_W:0]    new_sum;
    logic [LVL_W-1:0]  new_mid;
    logic [CNT_W-1:0]  div_ext;

    // |c - d| <= LOCK_TOL without wrap-around.
    function automatic logic in_tol(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] diff;
        diff = (c >= d) ? (c - d) : (d - c);
        return diff <= CNT_W'(LOCK_TOL);
    endfunction

    assign accept = start && ((state == IDLE) || (state == MONITOR));

    osc_period_meter #(
        .CNT_W (CNT_W)
    ) u_meter (
        .clock      (clock),
        .reset      (reset),
        .clear      (accept),
        .osc        (osc),
        .edge_pulse (edge_pulse),
        .period     (period),
        .sat        (sat)
    );

    // Search arithmetic for the DECIDE step.
    always_comb begin
        div_ext = CNT_W'(div_q);
        sum     = (LVL_W+1)'(lo) + (LVL_W+1)'(hi);
        mid     = sum[LVL_W:1];
        new_lo  = lo;
        new_hi  = hi;
        if (count_q <= div_ext) begin
            new_hi = mid;
        end else begin
            new_lo = mid + LVL_W'(1);
        end
        new_sum = (LVL_W+1)'(new_lo) + (LVL_W+1)'(new_hi);
        new_mid = new_sum[LVL_W:1];
    end

    // Calibration / monitor state machine with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_q      <= '0;
            lo         <= '0;
            hi         <= '0;
            verifying  <= 1'b0;
            settle_cnt <= '0;
            miss_cnt   <= '0;
            count_q    <= '0;
            dco        <= 1'b0;
            ext_trim   <= '0;
            trim_level <= '0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            cal_fail   <= 1'b0;
            no_osc     <= 1'b0;
        end else if (accept) begin
            if (div < LVL_W'(2)) begin
                cal_fail <= 1'b1;
                locked   <= 1'b0;
                state    <= IDLE;
            end else begin
                div_q      <= div;
                lo         <= '0;
                hi         <= LVL_W'(TRIM_MAX);
                verifying  <= 1'b0;
                settle_cnt <= '0;
                miss_cnt   <= '0;
                cal_fail   <= 1'b0;
                no_osc     <= 1'b0;
                locked     <= 1'b0;
                dco        <= 1'b1;
                busy       <= 1'b1;
                trim_level <= TRIM_MID;
                ext_trim   <= trim_therm(TRIM_MID);
                state      <= SETTLE;
            end
        end else if ((state != IDLE) && sat) begin
            no_osc   <= 1'b1;
            cal_fail <= 1'b1;
            locked   <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
        end else begin
            case (state)
                SETTLE: begin
                    if (edge_pulse) begin
                        if (settle_cnt == SET_W'(SETTLE_EDGES - 1)) begin
                            settle_cnt <= '0;
                            state      <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (edge_pulse) begin
                        count_q <= period;
                        state   <= verifying ? VERIFY : DECIDE;
                    end
                end
                DECIDE: begin
                    lo         <= new_lo;
                    hi         <= new_hi;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                    if (new_lo == new_hi) begin
                        verifying  <= 1'b1;
                        trim_level <= new_lo;
                        ext_trim   <= trim_therm(new_lo);
                    end else begin
                        trim_level <= new_mid;
                        ext_trim   <= trim_therm(new_mid);
                    end
                end
                VERIFY: begin
                    busy <= 1'b0;
                    if (in_tol(count_q, div_ext)) begin
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                        state    <= MONITOR;
                    end else begin
                        cal_fail <= 1'b1;
                        state    <= IDLE;
                    end
                end
                MONITOR: begin
                    if (edge_pulse) begin
                        if (in_tol(period, div_ext)) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == MISS_W'(FAIL_LIMIT - 1)) begin
                            miss_cnt <= '0;
                            locked   <= 1'b0;
                            cal_fail <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dco_trim_calibrator.md
Name: dco_trim_calibrator

Overview:
- Drives the DCO-mode trim interface of the digital PLL (dco, ext_trim).
- Finds, by binary search, the ring-oscillator trim level that makes the DCO run at div times the reference osc frequency, then monitors that the lock holds.
- Clocked by the DCO output (clockp[0]). osc is sampled as an asynchronous input.
- Lets firmware get a calibrated fixed DCO setting without running the closed-loop controller.

Parameters:
- SETTLE_EDGES, 2: osc rising edges discarded after every trim change before measuring.
- LOCK_TOL, 1: allowed |count - div| for lock, in DCO cycles.
- FAIL_LIMIT, 3: consecutive out-of-tolerance monitor measurements that drop lock.
- CNT_W, 8: width of the period counter. It saturates at 2^CNT_W-1.

Ports:
- clock  in  1  DCO clock (clockp[0]).
- reset  in  1  Async, active-high.
- start  in  1  Single-cycle pulse; begins calibration. Ignored while busy.
- osc  in  1  Reference oscillator, asynchronous.
- div  in  5  Target ratio, DCO cycles per osc period. Sampled at start.
- dco  out  1  High while this block owns the trim.
- ext_trim  out  26  Thermometer trim: the lowest trim_level bits are set.
- trim_level  out  5  Current trim level, 0..26.
- busy  out  1  High from the cycle after start until DONE or FAIL.
- locked  out  1  Calibrated and within tolerance.
- cal_fail  out  1  Sticky error. Cleared by the next accepted start.
- no_osc  out  1  Sticky: counter saturated with no osc edge. Cleared by start.

Behaviour:
- Reset (async, active-high): every output 0, state IDLE, counters 0. Reset mid-operation aborts immediately. After reset release, state is IDLE.
- Clock domain: everything on clock. No other clock domain.
- osc input: passes through a 2-flop synchronizer, then an edge-detect flop. A rising edge is flagged 3 cycles after the osc transition.
- Period count (cnt): cleared to 1 on each flagged edge; otherwise cnt+1, saturating at 2^CNT_W-1.
  - At each edge, the pre-clear value is the measured period.
  - If saturation is reached: set no_osc and cal_fail, clear locked, go to IDLE (dco stays at its current value).
- Trim direction: higher trim_level gives a slower DCO, so a smaller measured count.
- State machine:
  - IDLE: on start:
    - If div < 2: set cal_fail for good and stay in IDLE.
    - Otherwise latch div, lo=0, hi=26, clear sticky flags, dco=1, go to SETTLE.
  - SETTLE: trim_level = (lo+hi)>>1 during search; wait SETTLE_EDGES edges, then go to MEASURE.
  - MEASURE: wait one full osc period and capture the count at its closing edge.
  - DECIDE (1 cycle), with mid = (lo+hi)>>1:
    - If count <= div: hi = mid.
    - Else: lo = mid+1.
    - Then if lo == hi: trim_level = lo, go to VERIFY via SETTLE. Otherwise go to SETTLE.
    - At most 5 DECIDE passes.
  - VERIFY: one measurement.
    - If |count - div| <= LOCK_TOL: locked=1, busy=0, go to MONITOR.
    - Else: cal_fail=1, busy=0, go to IDLE. dco stays 1 and the trim is held.
  - MONITOR: measure each osc period.
    - An out-of-tolerance result increments a miss counter; an in-tolerance result clears it.
    - When the miss counter reaches FAIL_LIMIT: locked=0, cal_fail=1, go to IDLE.
    - start while in MONITOR restarts calibration. start is accepted in IDLE and MONITOR only.
- Output timing:
  - ext_trim and trim_level are registered; they change only on entry to SETTLE.
  - busy rises one cycle after an accepted start.
- Arithmetic: the tolerance compare uses the CNT_W-bit count against zero-extended div, as an absolute difference (no wrap). lo, hi and mid are 5-bit; mid never exceeds 26.
- Simultaneous start and osc edge: start takes priority. The edge is discarded and the counter is cleared.

Decomposition:
- Shared package dco_trim_pkg holds:
  - the state enum (IDLE, SETTLE, MEASURE, DECIDE, VERIFY, MONITOR);
  - TRIM_MAX = 26 and TRIM_BITS = 26;
  - a function mapping trim_level to the thermometer code.
- One natural sub-module: osc_period_meter. It contains the synchronizer, the edge detect, the saturating counter, and the outputs edge_pulse, period and sat.

Test Plan:
- Bench DCO model: osc period = 40 - trim_level clock cycles. Start with div=30 -> after at most 5 searches, trim_level=10, ext_trim=26'h00003FF, locked=1, busy=0, dco=1, cal_fail=0.
- Same model, div=14 -> search ends at trim_level=26 and count 14 -> locked=1. With div=12 -> count 14 at trim 26, outside tolerance -> cal_fail=1, locked=0.
- osc held low after start -> after 255 cycles, no_osc=1, cal_fail=1, busy=0.
- Locked at trim 10, then the model shifts the period to 36 -> after 3 measurements, locked=0 and cal_fail=1. A single-period glitch leaves locked=1.
- Reset asserted during MEASURE -> same cycle: ext_trim=0, dco=0, busy=0, locked=0. A start 2 cycles after release calibrates normally.
- start with div=1 -> cal_fail=1, busy stays 0, dco stays 0. A second start pulse while busy is ignored (the search sequence is unchanged).
